// File: rtl/cl_ocl_axil_bridge.sv
// AXI4-Lite slave bridging the Shell OCL BAR to the CL register core:
// AW/W pairs become a one-cycle core write strobe, AR requests are decoded against core readback.
module cl_ocl_axil_bridge #(
  parameter logic [31:0] HELLO_ADDR    = 32'h0000_0500,
  parameter logic [31:0] VLED_ADDR     = 32'h0000_0504,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main,
  input  logic        s_awvalid,
  input  logic [31:0] s_awaddr,
  output logic        s_awready,
  input  logic        s_wvalid,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_wready,
  output logic        s_bvalid,
  output logic [1:0]  s_bresp,
  input  logic        s_bready,
  input  logic        s_arvalid,
  input  logic [31:0] s_araddr,
  output logic        s_arready,
  output logic        s_rvalid,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  input  logic        s_rready,
  output logic [31:0] wr_addr,
  output logic [31:0] wdata,
  output logic        wready,
  input  logic [31:0] hello_world_q_byte_swapped,
  input  logic [15:0] vled_q
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_STROBE, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_DATA, RD_RESP} rd_state_e;

  wr_state_e           wr_state_q, wr_state_d;
  logic                aw_got_q, aw_got_d;
  logic                w_got_q, w_got_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic                awready_q, awready_d;
  logic                s_wready_q, s_wready_d;

  rd_state_e           rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [RESP_W-1:0]   rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic wstrb_unused;

  // Every write is a full word, so the strobes carry no information.
  assign wstrb_unused = ^s_wstrb;

  assign aw_hs = s_awvalid & awready_q;
  assign w_hs  = s_wvalid & s_wready_q;
  assign ar_hs = s_arvalid & arready_q;

  // Write channel: collect AW and W in any order, strobe the core, then respond on B.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    wready_d   = 1'b0;
    bvalid_d   = bvalid_q;
    awready_d  = 1'b0;
    s_wready_d = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_got_d  = 1'b1;
          wr_addr_d = s_awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_wdata;
        end
        if (aw_got_d && w_got_d) begin
          wr_state_d = WR_STROBE;
          wready_d   = 1'b1;
        end else begin
          awready_d  = !aw_got_d;
          s_wready_d = !w_got_d;
        end
      end
      WR_STROBE: begin
        aw_got_d   = 1'b0;
        w_got_d    = 1'b0;
        bvalid_d   = 1'b1;
        wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          s_wready_d = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
        bvalid_d   = 1'b0;
      end
    endcase
  end

  // Read channel: capture AR, decode one cycle later, hold R until accepted.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          araddr_d   = s_araddr;
          rd_state_d = RD_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      RD_DATA: begin
        rvalid_d   = 1'b1;
        rd_state_d = RD_RESP;
        if (araddr_q == HELLO_ADDR) begin
          rdata_d = hello_world_q_byte_swapped;
          rresp_d = RESP_OKAY;
        end else if (araddr_q == VLED_ADDR) begin
          rdata_d = {16'h0000, vled_q};
          rresp_d = RESP_OKAY;
        end else begin
          rdata_d = UNMAPPED_DATA;
          rresp_d = RESP_SLVERR;
        end
      end
      RD_RESP: begin
        if (s_rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        rvalid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      wr_state_q <= WR_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      awready_q  <= 1'b0;
      s_wready_q <= 1'b0;
      rd_state_q <= RD_IDLE;
      araddr_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      awready_q  <= awready_d;
      s_wready_q <= s_wready_d;
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = s_wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = RESP_OKAY;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign wr_addr   = wr_addr_q;
  assign wdata     = wdata_q;
  assign wready    = wready_q;

endmodule

// File: doc/cl_ocl_axil_bridge.md
Name: cl_ocl_axil_bridge

Overview:
- AXI4-Lite slave on the Shell OCL BAR that drives the CL register core's simple write port (wr_addr/wdata/wready) and services reads from it.
- Converts independent AW/W channel handshakes into a single-cycle write strobe plus a B response.
- Converts AR requests into an R response by decoding the address against the core's readback values (hello-world byte-swapped word, virtual LED shadow).
- Sits between the Shell OCL interface and the register core, all in the clk_main_a0 domain.

Parameters:
- HELLO_ADDR, 32'h0000_0500, read address returning hello_world_q_byte_swapped.
- VLED_ADDR, 32'h0000_0504, read address returning {16'h0, vled_q}.
- UNMAPPED_DATA, 32'hDEAD_BEEF, read data returned for any other address.

Ports:
- clk_main_a0  in  1  main clock.
- rst_main  in  1  reset, asynchronous, active-high.
- s_awvalid  in  1  write address valid.
- s_awaddr  in  32  write address.
- s_awready  out  1  write address ready.
- s_wvalid  in  1  write data valid.
- s_wdata  in  32  write data.
- s_wstrb  in  4  write strobes (ignored; every write is a full word).
- s_wready  out  1  write data ready.
- s_bvalid  out  1  write response valid.
- s_bresp  out  2  write response, always 2'b00.
- s_bready  in  1  write response ready.
- s_arvalid  in  1  read address valid.
- s_araddr  in  32  read address.
- s_arready  out  1  read address ready.
- s_rvalid  out  1  read data valid.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response.
- s_rready  in  1  read data ready.
- wr_addr  out  32  core write address.
- wdata  out  32  core write data.
- wready  out  1  core write strobe, one cycle per AXI write.
- hello_world_q_byte_swapped  in  32  core readback.
- vled_q  in  16  core virtual LED shadow.

Behaviour:
- Reset (async assert, sync release): every output and internal flop is 0; write FSM = WR_IDLE; read FSM = RD_IDLE.
- Write FSM states: WR_IDLE, WR_STROBE, WR_RESP.
- WR_IDLE: s_awready = !aw_got; s_wready = !w_got.
  - An AW handshake latches s_awaddr and sets aw_got.
  - A W handshake latches s_wdata and sets w_got.
  - The two handshakes may occur in the same cycle or in either order, any gap apart.
- When aw_got and w_got are both set, or both handshakes complete in the same cycle, go to WR_STROBE on the next edge.
- WR_STROBE: wready = 1 for exactly one cycle, with the latched wr_addr/wdata; clear both got flags; go to WR_RESP.
  - wr_addr/wdata hold their latched values until the next write.
- WR_RESP: s_bvalid = 1, s_bresp = 2'b00. Hold until s_bready; on the handshake return to WR_IDLE.
  - s_awready and s_wready are 0 throughout WR_STROBE and WR_RESP.
- Minimum write latency: AW+W handshake at cycle N → wready at N+1 → s_bvalid at N+2.
- Back-to-back writes are allowed; the next AW/W can be accepted in the cycle after the B handshake.
- Read FSM states: RD_IDLE, RD_DATA, RD_RESP.
- RD_IDLE: s_arready = 1. An AR handshake latches s_araddr and moves to RD_DATA.
- RD_DATA: register s_rdata and s_rresp from the latched address; go to RD_RESP. s_arready = 0.
  - araddr == HELLO_ADDR: s_rdata = hello_world_q_byte_swapped, s_rresp = 2'b00.
  - araddr == VLED_ADDR: s_rdata = {16'h0, vled_q}, s_rresp = 2'b00.
  - Any other address: s_rdata = UNMAPPED_DATA, s_rresp = 2'b10 (SLVERR).
  - Address compare uses all 32 bits.
- RD_RESP: s_rvalid = 1; s_rdata and s_rresp stable until s_rready; on the handshake return to RD_IDLE. s_arready = 0.
- Read latency: AR handshake at N → s_rvalid at N+2.
- Read and write FSMs are independent. No ordering is enforced between a concurrent read and write.
  - A read sampled in the same cycle as wready returns the core value from before the write.
- Reset mid-transaction: all valids and wready drop asynchronously and any in-flight transaction is discarded; no strobe is issued after reset release.

Test Plan:
- AW and W in the same cycle, addr 0x500, data 0x1234_5678 → wready pulses 1 cycle at N+1 with wr_addr=0x500, wdata=0x1234_5678; s_bvalid at N+2, bresp 0.
- W at cycle 3, AW at cycle 7 (addr 0x500, data 0xA5A5_0001) → exactly one wready pulse, at cycle 8; s_awready/s_wready low after each channel's handshake until the B handshake completes.
- s_bready held low 10 cycles after s_bvalid → s_bvalid stays 1, a second AW is not accepted, no extra wready; the second write proceeds after s_bready.
- Read 0x500 with hello_world_q_byte_swapped = 0x7856_3412 → s_rvalid at N+2, rdata 0x7856_3412, rresp 0. Read 0x504 with vled_q = 0x5678 → rdata 0x0000_5678.
- Read 0x508 → rdata 0xDEAD_BEEF, rresp 2'b10. With s_rready low 5 cycles, rdata stays stable and s_arready stays 0.
- rst_main asserted while in WR_RESP and RD_RESP → s_bvalid, s_rvalid and wready go 0 immediately; after release both FSMs are idle and s_awready = s_wready = s_arready = 1 on the next cycle.
